// File: rtl/flopr_pipe.sv
// flopr_pipe: elastic pipeline register. A WIDTH-bit payload moves through
// DEPTH register stages. The design tracks a valid bit per stage, collapses
// bubbles, stalls under backpressure, supports a synchronous flush and keeps
// a registered occupancy count.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high in the cycle before that edge. On the input side this is
// in_valid & in_ready. On the output side it is out_valid & out_ready, and
// out_valid is already masked by flush. A producer may assert valid without
// waiting for ready. While out_valid=1 and out_ready=0, out_data stays
// stable. in_ready is combinational from out_ready through the stage chain.
module flopr_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CW-1:0]    count
);

   logic [DEPTH-1:0] r_v;
   logic [WIDTH-1:0] r_d [DEPTH];
   logic [CW-1:0]    r_count;

   logic [DEPTH-1:0] w_adv;
   logic             w_in_ready;
   logic             w_push;
   logic             w_pop;

   // A stage may advance when some stage at or beyond it is empty, or when
   // the output is being drained. This is the unrolled form of
   // adv[i] = !v[i] | adv[i+1]. It avoids a self-referencing vector.
   for (genvar g = 0; g < DEPTH; g++) begin : g_adv
      assign w_adv[g] = out_ready | ~(&r_v[DEPTH-1:g]);
   end

   assign w_in_ready = w_adv[0] & ~flush;
   assign w_push     = in_valid & w_in_ready;
   assign w_pop      = r_v[DEPTH-1] & out_ready & ~flush;

   assign in_ready  = w_in_ready;
   assign out_valid = r_v[DEPTH-1] & ~flush;
   assign out_data  = r_d[DEPTH-1];
   assign count     = r_count;

   // Stage registers: reset clears everything. Flush drops the valid bits
   // and leaves the data. Otherwise each advancing stage loads from the
   // stage behind it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_v <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_d[i] <= '0;
         end
      end else if (flush) begin
         r_v <= '0;
      end else begin
         if (w_adv[0]) begin
            r_v[0] <= w_push;
            r_d[0] <= in_data;
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (w_adv[i]) begin
               r_v[i] <= r_v[i-1];
               r_d[i] <= r_d[i-1];
            end
         end
      end
   end

   // Occupancy: count input and output transfers. A push and a pop in the
   // same cycle cancel, so the count always equals the number of set valid
   // bits.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_count <= '0;
      end else if (w_push && !w_pop) begin
         r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
         r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: tb/tb_flopr_pipe.sv
// tb_flopr_pipe: scenario tests plus randomized traffic for flopr_pipe
// (WIDTH=8, DEPTH=3). The reference model is an ordered queue of in-flight
// entries. Each entry carries the edge number at which it was accepted. The
// head is visible at the output once it has aged DEPTH-1 edges.
module tb_flopr_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;

   logic             clk;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [1:0]       count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [WIDTH-1:0] exp_q[$];
   int               acc_q[$];

   flopr_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic bit m_out_valid();
      return !flush && exp_q.size() > 0 && (cyc - acc_q[0] >= DEPTH - 1);
   endfunction

   function automatic bit m_in_ready();
      return !flush && (exp_q.size() < DEPTH || out_ready);
   endfunction

   // Advance one clock edge and apply that edge to the model.
   task automatic tick();
      bit               pop;
      bit               push;
      bit               clr;
      logic [WIDTH-1:0] d;
      pop  = m_out_valid() && out_ready;
      push = in_valid && m_in_ready();
      clr  = reset || flush;
      d    = in_data;
      @(posedge clk);
      cyc++;
      if (clr) begin
         exp_q.delete();
         acc_q.delete();
      end else begin
         if (pop) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
         end
         if (push) begin
            exp_q.push_back(d);
            acc_q.push_back(cyc);
         end
      end
      #1;
   endtask

   // ---------------- driver ----------------
   task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
         end
         checks++;
         if (out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_out_data: got %h expected 00", out_data);
         end
         checks++;
         if (count !== 2'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d expected 0", count);
         end
      end
      reset = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      tick();
   endtask

   task automatic test_streaming();
      logic [WIDTH-1:0] vals [6];
      int pushes;
      int pops;
      vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'h5A;
      vals[3] = 8'h01; vals[4] = 8'h02; vals[5] = 8'h03;
      for (int i = 0; i < 10; i++) begin
         drive(i < 6, (i < 6) ? vals[i] : 8'h00, 1'b1, 1'b0);
         @(negedge clk);
         pushes = (i < 6) ? i : 6;
         pops   = (i > 3) ? i - 3 : 0;
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready);
         end
         checks++;
         if (count !== 2'(pushes - pops)) begin
            failures++;
            $display("FAIL stream_count[%0d]: got %0d expected %0d", i, count, pushes - pops);
         end
         checks++;
         if (out_valid !== (i >= 3 && i < 9)) begin
            failures++;
            $display("FAIL stream_out_valid[%0d]: got %b expected %b", i, out_valid, (i >= 3 && i < 9));
         end
         if (i >= 3 && i < 9) begin
            checks++;
            if (out_data !== vals[i-3]) begin
               failures++;
               $display("FAIL stream_out_data[%0d]: got %h expected %h", i, out_data, vals[i-3]);
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] vals [4];
      logic [WIDTH-1:0] got[$];
      logic [WIDTH-1:0] g;
      bit               acc44;
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, vals[(i < 3) ? i : 3], 1'b0, 1'b0);
         @(negedge clk);
         checks++;
         if (in_ready !== (i < 3)) begin
            failures++;
            $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, in_ready, (i < 3));
         end
         if (i >= 3) begin
            checks++;
            if (count !== 2'd3) begin
               failures++;
               $display("FAIL bp_count[%0d]: got %0d expected 3", i, count);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h11) begin
               failures++;
               $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=11", i, out_valid, out_data);
            end
         end
         tick();
      end
      acc44 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         drive(!acc44, 8'h44, 1'b1, 1'b0);
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (in_ready !== 1'b1) begin
               failures++;
               $display("FAIL bp_full_ready: got %b expected 1", in_ready);
            end
         end
         if (out_valid === 1'b1) got.push_back(out_data);
         if (in_ready === 1'b1 && in_valid) acc44 = 1'b1;
         tick();
      end
      checks++;
      if (got.size() != 4) begin
         failures++;
         $display("FAIL bp_out_count: got %0d expected 4", got.size());
      end
      for (int k = 0; k < 4; k++) begin
         g = (k < got.size()) ? got[k] : 8'hxx;
         checks++;
         if (g !== vals[k]) begin
            failures++;
            $display("FAIL bp_order[%0d]: got %h expected %h", k, g, vals[k]);
         end
      end
   endtask

   task automatic test_bubble();
      logic [WIDTH-1:0] vals [3];
      logic [WIDTH-1:0] got[$];
      logic [WIDTH-1:0] g;
      vals[0] = 8'h7E; vals[1] = 8'h81; vals[2] = 8'h82;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: drive(1'b1, 8'h7E, 1'b0, 1'b0);
            3: drive(1'b1, 8'h81, 1'b0, 1'b0);
            4: drive(1'b1, 8'h82, 1'b0, 1'b0);
            default: drive(1'b0, 8'h00, 1'b0, 1'b0);
         endcase
         @(negedge clk);
         if (i == 1 || i == 2) begin
            checks++;
            if (out_valid !== 1'b0) begin
               failures++;
               $display("FAIL bubble_latency[%0d]: got %b expected 0", i, out_valid);
            end
         end
         if (i == 3) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h7E || count !== 2'd1 || in_ready !== 1'b1) begin
               failures++;
               $display("FAIL bubble_arrive: got v=%b d=%h cnt=%0d rdy=%b expected v=1 d=7e cnt=1 rdy=1",
                        out_valid, out_data, count, in_ready);
            end
         end
         if (i == 5) begin
            checks++;
            if (count !== 2'd3 || in_ready !== 1'b0) begin
               failures++;
               $display("FAIL bubble_full: got cnt=%0d rdy=%b expected cnt=3 rdy=0", count, in_ready);
            end
         end
         tick();
      end
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         @(negedge clk);
         if (out_valid === 1'b1) got.push_back(out_data);
         tick();
      end
      checks++;
      if (got.size() != 3) begin
         failures++;
         $display("FAIL bubble_out_count: got %0d expected 3", got.size());
      end
      for (int k = 0; k < 3; k++) begin
         g = (k < got.size()) ? got[k] : 8'hxx;
         checks++;
         if (g !== vals[k]) begin
            failures++;
            $display("FAIL bubble_order[%0d]: got %h expected %h", k, g, vals[k]);
         end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 8'hFF, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (count !== 2'd3) begin
         failures++;
         $display("FAIL flush_pre_count: got %0d expected 3", count);
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_mask: got rdy=%b v=%b expected rdy=0 v=0", in_ready, out_valid);
      end
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || count !== 2'd0) begin
            failures++;
            $display("FAIL flush_after[%0d]: got v=%b cnt=%0d d=%h expected v=0 cnt=0", i, out_valid, count, out_data);
         end
         tick();
      end
   endtask

   task automatic test_full_pass();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'hD1 + 8'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 8'h99, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (count !== 2'd3 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL pass_accept: got cnt=%0d rdy=%b expected cnt=3 rdy=1", count, in_ready);
      end
      tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (count !== 2'd3 || out_data !== 8'hD2) begin
         failures++;
         $display("FAIL pass_edge1: got cnt=%0d d=%h expected cnt=3 d=d2", count, out_data);
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hD3) begin
         failures++;
         $display("FAIL pass_edge2: got v=%b d=%h expected v=1 d=d3", out_valid, out_data);
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h99 || count !== 2'd1) begin
         failures++;
         $display("FAIL pass_edge3: got v=%b d=%h cnt=%0d expected v=1 d=99 cnt=1", out_valid, out_data, count);
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         failures++;
         $display("FAIL pass_drained: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, count);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 79) == 0);
         drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
               (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
               $urandom_range(0, 29) == 0);
         @(negedge clk);
         checks++;
         if (out_valid !== m_out_valid()) begin
            failures++;
            $display("FAIL rand_out_valid[%0d]: got %b expected %b", i, out_valid, m_out_valid());
         end
         checks++;
         if (in_ready !== m_in_ready()) begin
            failures++;
            $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, in_ready, m_in_ready());
         end
         checks++;
         if (count !== 2'(exp_q.size())) begin
            failures++;
            $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count, exp_q.size());
         end
         if (m_out_valid()) begin
            checks++;
            if (out_data !== exp_q[0]) begin
               failures++;
               $display("FAIL rand_out_data[%0d]: got %h expected %h", i, out_data, exp_q[0]);
            end
         end
         tick();
      end
      reset = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_bubble();
      test_flush();
      test_full_pass();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
